btn_cond: RTL and testbench



---
 rtl/btn_cond.sv | 197 +++++++++++++++++++
 tb/tb_btn_cond.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// btn_cond: button front end for the washing-machine controller.
// Each raw button is synchronised, debounced and turned into one-cycle
// press/release pulses. Buttons enabled in REP_MASK auto-repeat while held.
// The centre button (bit 4) also fires a single long-press pulse.
// Bit order everywhere is {bt, l_bt, r_bt, u_bt, d_bt}.
module btn_cond #(
  parameter int         DEB_CYCLES   = 2000000,
  parameter int         REPEAT_DELAY = 50000000,
  parameter int         REPEAT_RATE  = 10000000,
  parameter int         LONG_CYCLES  = 200000000,
  parameter logic [4:0] REP_MASK     = 5'b00011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_lvl,
  output logic [4:0] press_p,
  output logic [4:0] rel_p,
  output logic       long_p
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DW       = $clog2(DEB_CYCLES) + 1;
  localparam int HW       = $clog2(HOLD_MAX) + 1;
  localparam int LW       = $clog2(LONG_CYCLES) + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);
  localparam logic [LW-1:0] LONG_LAST  = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_FULL  = LW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } holdState_t;

  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [4:0]    r_lvl;
  logic [DW-1:0] r_debCnt [5];
  logic [4:0]    r_press;
  logic [4:0]    r_rel;
  logic          r_long;
  logic [LW-1:0] r_longCnt;

  holdState_t    r_state     [5];
  logic [HW-1:0] r_holdCnt   [5];
  holdState_t    w_nextState [5];
  logic [HW-1:0] w_nextCnt   [5];

  logic [4:0]    w_pressEv;
  logic [4:0]    w_relEv;
  logic [4:0]    w_repPulse;

  // Two-flop synchroniser so nothing downstream ever sees the raw pins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level change is accepted on the edge where the disagreement has lasted DEB_CYCLES samples
  always_comb begin
    w_pressEv = '0;
    w_relEv   = '0;
    for (int i = 0; i < 5; i++) begin
      if ((r_sync2[i] != r_lvl[i]) && (r_debCnt[i] == DEB_LAST)) begin
        if (r_sync2[i]) begin
          w_pressEv[i] = 1'b1;
        end else begin
          w_relEv[i] = 1'b1;
        end
      end
    end
  end

  // Debounce counters: clear on agreement, count on disagreement, flip the level when accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl <= '0;
      for (int i = 0; i < 5; i++) begin
        r_debCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == DEB_LAST) begin
          r_debCnt[i] <= '0;
          r_lvl[i]    <= ~r_lvl[i];
        end else begin
          r_debCnt[i] <= r_debCnt[i] + DW'(1);
        end
      end
    end
  end

  // Hold FSM next state: release always wins over a repeat falling on the same edge
  always_comb begin
    w_repPulse = '0;
    for (int i = 0; i < 5; i++) begin
      w_nextState[i] = r_state[i];
      w_nextCnt[i]   = r_holdCnt[i];
      unique case (r_state[i])
        IDLE: begin
          if (w_pressEv[i]) begin
            w_nextState[i] = HELD;
            w_nextCnt[i]   = '0;
          end
        end
        HELD: begin
          if (w_relEv[i]) begin
            w_nextState[i] = IDLE;
            w_nextCnt[i]   = '0;
          end else if (REP_MASK[i] && (r_holdCnt[i] == DELAY_LAST)) begin
            w_repPulse[i]  = 1'b1;
            w_nextState[i] = REPEAT;
            w_nextCnt[i]   = '0;
          end else if (r_holdCnt[i] != DELAY_LAST) begin
            w_nextCnt[i] = r_holdCnt[i] + HW'(1);
          end
        end
        REPEAT: begin
          if (w_relEv[i]) begin
            w_nextState[i] = IDLE;
            w_nextCnt[i]   = '0;
          end else if (r_holdCnt[i] == RATE_LAST) begin
            w_repPulse[i] = 1'b1;
            w_nextCnt[i]  = '0;
          end else begin
            w_nextCnt[i] = r_holdCnt[i] + HW'(1);
          end
        end
        default: begin
          w_nextState[i] = IDLE;
          w_nextCnt[i]   = '0;
        end
      endcase
    end
  end

  // Hold FSM state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        r_state[i]   <= IDLE;
        r_holdCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        r_state[i]   <= w_nextState[i];
        r_holdCnt[i] <= w_nextCnt[i];
      end
    end
  end

  // Registered pulse outputs; repeats share the press output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press <= '0;
      r_rel   <= '0;
    end else begin
      r_press <= w_pressEv | w_repPulse;
      r_rel   <= w_relEv;
    end
  end

  // Long-press counter on bt: fires once, then parks one past the trigger value until release
  always_ff @(posedge clk) begin
    if (rst) begin
      r_longCnt <= '0;
      r_long    <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_lvl[4]) begin
        r_longCnt <= '0;
      end else if (r_longCnt == LONG_LAST) begin
        r_longCnt <= LONG_FULL;
        r_long    <= 1'b1;
      end else if (r_longCnt != LONG_FULL) begin
        r_longCnt <= r_longCnt + LW'(1);
      end
    end
  end

  assign btn_lvl = r_lvl;
  assign press_p = r_press;
  assign rel_p   = r_rel;
  assign long_p  = r_long;

endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond: directed bench for btn_cond with short timing parameters.
// Each scenario starts at tick 0; a raw change made right after tick N is
// first sampled on the next edge and is accepted at tick N+6.
module tb_btn_cond;

  logic       clk;
  logic       rst;
  logic [4:0] btnRaw;
  logic [4:0] btnLvl;
  logic [4:0] pressP;
  logic [4:0] relP;
  logic       longP;

  int checkCount;
  int errCount;
  int t;

  logic [4:0] pressLog [0:127];
  logic [4:0] relLog   [0:127];
  logic [4:0] lvlLog   [0:127];
  logic       longLog  [0:127];

  btn_cond #(
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (8),
    .LONG_CYCLES (30),
    .REP_MASK    (5'b00011)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btnRaw),
    .btn_lvl(btnLvl),
    .press_p(pressP),
    .rel_p  (relP),
    .long_p (longP)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] raw);
    btnRaw = raw;
  endtask

  task automatic startScenario(input string name);
    t = 0;
    for (int i = 0; i < 128; i++) begin
      pressLog[i] = '0;
      relLog[i]   = '0;
      lvlLog[i]   = '0;
      longLog[i]  = 1'b0;
    end
    $display("[TB] scenario: %s", name);
  endtask

  task automatic runUntil(input int target);
    while (t < target) begin
      @(posedge clk);
      #1;
      t++;
      if (t < 128) begin
        pressLog[t] = pressP;
        relLog[t]   = relP;
        lvlLog[t]   = btnLvl;
        longLog[t]  = longP;
      end
    end
  endtask

  // Counts ticks in [lo,hi] where the selected log has any bit of m set (kind 0 press, 1 rel, 2 long)
  function automatic int pulses(input int kind, input logic [4:0] m, input int lo, input int hi);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (kind == 0 && (pressLog[i] & m) != 5'b0) n++;
      if (kind == 1 && (relLog[i] & m) != 5'b0) n++;
      if (kind == 2 && longLog[i]) n++;
    end
    return n;
  endfunction

  initial begin
    checkCount = 0;
    errCount   = 0;
    t          = 0;
    rst        = 1'b1;
    applyStimulus(5'b00000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset lvl", btnLvl, 5'b00000);
    checkOutput("reset press", pressP, 5'b00000);
    checkOutput("reset rel", relP, 5'b00000);
    checkOutput("reset long", longP, 1'b0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    startScenario("clean press on u");
    applyStimulus(5'b00010);
    runUntil(50);
    applyStimulus(5'b00000);
    runUntil(70);
    checkOutput("u early", pressLog[5], 5'b00000);
    checkOutput("u press", pressLog[6], 5'b00010);
    checkOutput("u one cycle", pressLog[7], 5'b00000);
    checkOutput("u lvl held", lvlLog[20], 5'b00010);
    checkOutput("u before rep1", pressLog[25], 5'b00000);
    checkOutput("u rep1", pressLog[26], 5'b00010);
    checkOutput("u rep2", pressLog[34], 5'b00010);
    checkOutput("u rep3", pressLog[42], 5'b00010);
    checkOutput("u rep4", pressLog[50], 5'b00010);
    checkOutput("u press count", pulses(0, 5'b00010, 1, 70), 5);
    checkOutput("u rel", relLog[56], 5'b00010);
    checkOutput("u rel count", pulses(1, 5'b11111, 1, 70), 1);
    checkOutput("u lvl released", lvlLog[70], 5'b00000);

    startScenario("bounce on l");
    applyStimulus(5'b01000);
    runUntil(2);
    applyStimulus(5'b00000);
    runUntil(4);
    applyStimulus(5'b01000);
    runUntil(6);
    applyStimulus(5'b00000);
    runUntil(8);
    applyStimulus(5'b01000);
    runUntil(30);
    checkOutput("l quiet bounce", pulses(0, 5'b11111, 1, 13), 0);
    checkOutput("l lvl during bounce", lvlLog[13], 5'b00000);
    checkOutput("l press", pressLog[14], 5'b01000);
    checkOutput("l press count", pulses(0, 5'b11111, 1, 30), 1);
    checkOutput("l no rel", pulses(1, 5'b11111, 1, 30), 0);
    checkOutput("l lvl after", lvlLog[30], 5'b01000);
    applyStimulus(5'b00000);
    runUntil(40);
    checkOutput("l rel", relLog[36], 5'b01000);

    startScenario("masked r held");
    applyStimulus(5'b00100);
    runUntil(100);
    applyStimulus(5'b00000);
    runUntil(115);
    checkOutput("r press", pressLog[6], 5'b00100);
    checkOutput("r press count", pulses(0, 5'b00100, 1, 115), 1);
    checkOutput("r rel", relLog[106], 5'b00100);
    checkOutput("r rel count", pulses(1, 5'b00100, 1, 115), 1);
    checkOutput("r other press", pulses(0, 5'b11011, 1, 115), 0);
    checkOutput("r other rel", pulses(1, 5'b11011, 1, 115), 0);
    checkOutput("r no long", pulses(2, 5'b00000, 1, 115), 0);

    startScenario("long press on bt");
    applyStimulus(5'b10000);
    runUntil(40);
    applyStimulus(5'b00000);
    runUntil(55);
    checkOutput("bt press", pressLog[6], 5'b10000);
    checkOutput("bt press count", pulses(0, 5'b10000, 1, 55), 1);
    checkOutput("bt long early", longLog[35], 1'b0);
    checkOutput("bt long", longLog[36], 1'b1);
    checkOutput("bt long count", pulses(2, 5'b00000, 1, 55), 1);
    checkOutput("bt rel", relLog[46], 5'b10000);

    startScenario("simultaneous u and d");
    applyStimulus(5'b00011);
    runUntil(40);
    applyStimulus(5'b00000);
    runUntil(55);
    checkOutput("ud press", pressLog[6], 5'b00011);
    checkOutput("ud rep1", pressLog[26], 5'b00011);
    checkOutput("ud rep2", pressLog[34], 5'b00011);
    checkOutput("ud rep3", pressLog[42], 5'b00011);
    checkOutput("ud press cycles", pulses(0, 5'b11111, 1, 55), 4);
    checkOutput("ud rel", relLog[46], 5'b00011);

    startScenario("reset while d repeats");
    applyStimulus(5'b00001);
    runUntil(30);
    rst = 1'b1;
    runUntil(32);
    rst = 1'b0;
    runUntil(45);
    applyStimulus(5'b00000);
    runUntil(60);
    checkOutput("d rep before rst", pressLog[26], 5'b00001);
    checkOutput("d lvl in rst a", lvlLog[31], 5'b00000);
    checkOutput("d lvl in rst b", lvlLog[32], 5'b00000);
    checkOutput("d quiet after rst", pulses(0, 5'b11111, 31, 37), 0);
    checkOutput("d no rel on rst", pulses(1, 5'b11111, 27, 50), 0);
    checkOutput("d fresh press", pressLog[38], 5'b00001);
    checkOutput("d lvl repressed", lvlLog[38], 5'b00001);
    checkOutput("d no extra press", pulses(0, 5'b11111, 39, 60), 0);
    checkOutput("d rel", relLog[51], 5'b00001);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
